ram_copy_engine: RTL and testbench
==================================

// Module: ram_copy_engine
// PURPOSE
//  Bus initiator for the RAM64 word memory. It drives the memory's address, load and in
//  pins and samples its out pin, copying a block of len words from src to dst.
//  It sits beside the RAM64 instance and owns the memory port while busy.
//  Control uses a start/busy/done handshake.
//  Each word takes a read cycle then a write cycle.
// PARAMETERS
//  ADDR_W  6   memory address width (RAM64); addresses wrap modulo 2**ADDR_W
//  DATA_W  16  memory word width
// PORTS
//  clk          in   1         system clock; all state updates on rising edge
//  rst_n        in   1         asynchronous active-low reset
//  start        in   1         request a copy; sampled only in IDLE
//  src          in   ADDR_W    first source address, captured with start
//  dst          in   ADDR_W    first destination address, captured with start
//  len          in   ADDR_W+1  word count 0..64, captured with start; values >64 are saturated to 64
//  busy         out  1         high in READ and WRITE
//  done         out  1         one-cycle pulse when the copy finishes (DONE state)
//  mem_address  out  ADDR_W    to RAM64 address
//  mem_load     out  1         to RAM64 load; high only in WRITE
//  mem_in       out  DATA_W    to RAM64 in; equals the hold register
//  mem_out      in   DATA_W    from RAM64 out (combinational read of mem_address)
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; cur_src, cur_dst, count and hold all cleared to 0.
//   - busy=0, done=0, mem_load=0, mem_address=0, mem_in=0.
//   - Reset mid-copy aborts immediately; words already written stay written; no done pulse.
//  Outputs are Moore and decoded from registered state only. There is no combinational path from start/src/dst/len.
//  States:
//   - IDLE: mem_address=0, mem_load=0.
//     - start=1 at an edge: capture src/dst/len (saturated).
//     - If len=0, go to DONE; otherwise go to READ.
//   - READ: mem_address=cur_src, mem_load=0.
//     - At the edge: hold<=mem_out; go to WRITE.
//   - WRITE: mem_address=cur_dst, mem_load=1, mem_in=hold; RAM64 stores on this edge.
//     - cur_src<=cur_src+1 and cur_dst<=cur_dst+1, both mod 64. count<=count-1.
//     - If count was 1, go to DONE; otherwise go to READ.
//   - DONE: done=1, busy=0; unconditionally go to IDLE next edge. start is ignored in DONE.
//  Handshake rules:
//   - start is ignored in READ, WRITE and DONE (no queueing).
//   - Inputs may change freely after the capture edge.
//  Latency: for len=N>0, done is high in the cycle 2N+1 after the capture edge; for N=0, in cycle 1.
//  Ordering and overlap:
//   - Words are copied strictly ascending, each word read before it is written.
//   - An overlapping forward copy (dst inside src..src+N-1) therefore propagates already-copied data. This is defined behaviour, not an error.
//   - src=dst is a legal no-op rewrite.
//  Wrap: any range crossing address 63 continues at 0; len=64 touches every address exactly once.
//  count width is ADDR_W+1 so that 64 fits.
// TESTING
//  T1 reset: hold rst_n=0 with start=1 -> busy=0, done=0, mem_load=0, mem_address=0.
//     Release -> stays IDLE until the next edge with start=1.
//  T2 basic: preload mem[2..4]=0x1111,0x2222,0x3333; start src=2 dst=10 len=3.
//     -> mem[10..12] match; mem_load high exactly 3 cycles; done in cycle 7; mem[13] unchanged.
//  T3 wrap: mem[62,63,0,1]=A,B,C,D; src=62 dst=20 len=4 -> mem[20..23]=A,B,C,D.
//     Also dst=62 src=30 len=4 -> writes hit 62,63,0,1.
//  T4 edges:
//     - len=0 -> done in cycle 1, mem_load never asserted.
//     - len=100 -> 64 words copied, done in cycle 129.
//  T5 overlap: mem[0]=0xAAAA, mem[1..3]=0; src=0 dst=1 len=3 -> mem[0..3] all 0xAAAA.
//  T6 control: start pulsed during WRITE of a len=5 copy -> ignored (one done only).
//     rst_n low in the 4th WRITE -> outputs 0 at once; 3 words copied, no done pulse.

Source files
------------

// File: rtl/ram_copy_engine.sv
`default_nettype none
// ============================================================================
//  Module   : ram_copy_engine
//  Purpose  : Bus initiator for a RAM64-style word memory. Copies a block of
//             len words from src to dst, one read cycle followed by one
//             write cycle per word, in strictly ascending address order.
//             Addresses wrap modulo 2**ADDR_W.
//  Ports    : clk, rst_n        clock, asynchronous active-low reset
//             start             copy request, sampled only when idle
//             src, dst, len     block description, captured with start
//                               (len above 2**ADDR_W saturates)
//             busy, done        busy during READ/WRITE, done one-cycle pulse
//             mem_address       memory address
//             mem_load          memory write enable (WRITE state only)
//             mem_in            write data (hold register)
//             mem_out           memory read data (combinational read)
//  Revision : 1.0  initial release
// ============================================================================
module ram_copy_engine #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_load,
    output logic [DATA_W-1:0] mem_in,
    input  logic [DATA_W-1:0] mem_out
);

    // Largest legal block: the whole address space.
    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] cur_src;
    logic [ADDR_W-1:0] cur_dst;
    logic [ADDR_W:0]   count;
    logic [DATA_W-1:0] hold;
    logic [ADDR_W:0]   len_sat;

    assign len_sat = (len > MAX_LEN) ? MAX_LEN : len;

    // Write data is always the hold register; it only matters while mem_load=1.
    assign mem_in = hold;

    // All outputs are registered alongside the state so that they are
    // decoded from state only: each transition sets the values the next
    // state must present.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cur_src     <= '0;
            cur_dst     <= '0;
            count       <= '0;
            hold        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            mem_load    <= 1'b0;
            mem_address <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done        <= 1'b0;
                    mem_load    <= 1'b0;
                    mem_address <= '0;
                    if (start) begin
                        cur_src <= src;
                        cur_dst <= dst;
                        count   <= len_sat;
                        if (len_sat == '0) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state       <= READ;
                            busy        <= 1'b1;
                            mem_address <= src;
                        end
                    end
                end

                READ: begin
                    hold        <= mem_out;
                    state       <= WRITE;
                    mem_address <= cur_dst;
                    mem_load    <= 1'b1;
                end

                WRITE: begin
                    // The memory stores hold at cur_dst on this edge.
                    cur_src  <= cur_src + ADDR_W'(1);
                    cur_dst  <= cur_dst + ADDR_W'(1);
                    count    <= count - (ADDR_W + 1)'(1);
                    mem_load <= 1'b0;
                    if (count == (ADDR_W + 1)'(1)) begin
                        state       <= DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        mem_address <= '0;
                    end else begin
                        state       <= READ;
                        mem_address <= cur_src + ADDR_W'(1);
                    end
                end

                DONE: begin
                    // start is deliberately not looked at here: no queueing.
                    state       <= IDLE;
                    done        <= 1'b0;
                    busy        <= 1'b0;
                    mem_load    <= 1'b0;
                    mem_address <= '0;
                end

                default: begin
                    state       <= IDLE;
                    busy        <= 1'b0;
                    done        <= 1'b0;
                    mem_load    <= 1'b0;
                    mem_address <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_copy_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_copy_engine
//  Purpose  : Self-checking bench for ram_copy_engine with a RAM64 model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ram_copy_engine;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [5:0]  src;
    logic [5:0]  dst;
    logic [6:0]  len;
    logic        busy;
    logic        done;
    logic [5:0]  mem_address;
    logic        mem_load;
    logic [15:0] mem_in;
    logic [15:0] mem_out;

    ram_copy_engine #(.ADDR_W(6), .DATA_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .src         (src),
        .dst         (dst),
        .len         (len),
        .busy        (busy),
        .done        (done),
        .mem_address (mem_address),
        .mem_load    (mem_load),
        .mem_in      (mem_in),
        .mem_out     (mem_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM64 model: combinational read, write on rising edge. The bench loads
    // it through a back-door port used only while the engine is idle.
    logic [15:0] mem [64];
    logic        tb_we;
    logic [5:0]  tb_waddr;
    logic [15:0] tb_wdata;

    assign mem_out = mem[mem_address];

    always @(posedge clk) begin
        if (mem_load)   mem[mem_address] <= mem_in;
        else if (tb_we) mem[tb_waddr]    <= tb_wdata;
    end

    logic [15:0] ref_mem [64];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [5:0] a, input logic [15:0] d);
        @(negedge clk);
        tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
        ref_mem[a] = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic fill_pattern();
        for (int i = 0; i < 64; i++) poke(6'(i), 16'hC000 + 16'(i));
    endtask

    task automatic ref_copy(input logic [5:0] s, input logic [5:0] d, input int n);
        for (int i = 0; i < n; i++) ref_mem[6'(d + 6'(i))] = ref_mem[6'(s + 6'(i))];
    endtask

    task automatic cmp_image(input string name);
        int bad;
        int first;
        bad = 0; first = -1;
        for (int i = 0; i < 64; i++)
            if (mem[i] !== ref_mem[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        if (bad != 0) $display("mem_image first differing address %0d", first);
        chk(name, 64'(bad), 64'd0);
    endtask

    // Launch a copy and observe window cycles; cycle 1 is the one right after
    // the capture edge. start is re-asserted for cycles poke_from..poke_to.
    task automatic run_copy(input logic [5:0] s, input logic [5:0] d, input logic [6:0] l,
                            input int poke_from, input int poke_to, input int window,
                            output int dcyc, output int loads, output int bcyc, output int dcount);
        @(negedge clk);
        src = s; dst = d; len = l; start = 1'b1;
        @(posedge clk);
        dcyc = -1; loads = 0; bcyc = 0; dcount = 0;
        for (int c = 1; c <= window; c++) begin
            @(negedge clk);
            start = (c >= poke_from) && (c <= poke_to);
            src = 6'($urandom); dst = 6'($urandom); len = 7'($urandom);
            if (done) begin
                dcount++;
                if (dcyc < 0) dcyc = c;
            end
            if (mem_load) loads++;
            if (busy) bcyc++;
        end
        start = 1'b0;
    endtask

    typedef struct {
        logic [5:0]  src;
        logic [5:0]  dst;
        logic [6:0]  len;
        int          exp_done;
        int          exp_loads;
        logic [5:0]  pre_addr;
        int          pre_n;
        logic [63:0] pre_v;
        logic [5:0]  chk_addr;
        int          chk_n;
        logic [63:0] chk_v;
    } vec_t;

    function automatic vec_t mk(input logic [5:0] s, input logic [5:0] d, input logic [6:0] l,
                                input int ed, input int el,
                                input logic [5:0] pa, input int pn, input logic [63:0] pv,
                                input logic [5:0] ca, input int cn, input logic [63:0] cv);
        vec_t v;
        v.src = s; v.dst = d; v.len = l; v.exp_done = ed; v.exp_loads = el;
        v.pre_addr = pa; v.pre_n = pn; v.pre_v = pv;
        v.chk_addr = ca; v.chk_n = cn; v.chk_v = cv;
        return v;
    endfunction

    vec_t vecs [8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcyc, loads, bcyc, dcount;
        int n_eff;
        int quiet;

        // Word i of pre_v/chk_v sits at bits [16*i +: 16].
        vecs[0] = mk(6'd2,  6'd10, 7'd3,   7,   3, 6'd2,  3, {16'h0000, 16'h3333, 16'h2222, 16'h1111},
                     6'd10, 4, {16'hC00D, 16'h3333, 16'h2222, 16'h1111});
        vecs[1] = mk(6'd62, 6'd20, 7'd4,   9,   4, 6'd62, 4, {16'hA004, 16'hA003, 16'hA002, 16'hA001},
                     6'd20, 4, {16'hA004, 16'hA003, 16'hA002, 16'hA001});
        vecs[2] = mk(6'd30, 6'd62, 7'd4,   9,   4, 6'd30, 4, {16'h5004, 16'h5003, 16'h5002, 16'h5001},
                     6'd62, 4, {16'h5004, 16'h5003, 16'h5002, 16'h5001});
        vecs[3] = mk(6'd5,  6'd9,  7'd0,   1,   0, 6'd0,  0, 64'd0,
                     6'd9,  1, {48'd0, 16'hC009});
        vecs[4] = mk(6'd0,  6'd0,  7'd100, 129, 64, 6'd0, 0, 64'd0,
                     6'd63, 1, {48'd0, 16'hC03F});
        vecs[5] = mk(6'd0,  6'd1,  7'd3,   7,   3, 6'd0,  4, {16'h0000, 16'h0000, 16'h0000, 16'hAAAA},
                     6'd0,  4, {16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA});
        vecs[6] = mk(6'd40, 6'd45, 7'd2,   5,   2, 6'd0,  0, 64'd0,
                     6'd45, 3, {16'h0000, 16'hC02F, 16'hC029, 16'hC028});
        vecs[7] = mk(6'd7,  6'd7,  7'd2,   5,   2, 6'd0,  0, 64'd0,
                     6'd7,  2, {16'h0000, 16'h0000, 16'hC008, 16'hC007});

        tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;
        src = '0; dst = '0; len = '0;

        // ---- reset held with start high ----
        rst_n = 1'b0; start = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_busy",     64'(busy),        64'd0);
        chk("reset_done",     64'(done),        64'd0);
        chk("reset_load",     64'(mem_load),    64'd0);
        chk("reset_address",  64'(mem_address), 64'd0);
        chk("reset_mem_in",   64'(mem_in),      64'd0);
        start = 1'b0; rst_n = 1'b1;
        quiet = 0;
        repeat (3) begin
            @(negedge clk);
            if (busy || done || mem_load) quiet++;
        end
        chk("idle_after_reset", 64'(quiet), 64'd0);

        // ---- table-driven copies ----
        for (int v = 0; v < 8; v++) begin
            fill_pattern();
            for (int i = 0; i < vecs[v].pre_n; i++)
                poke(6'(vecs[v].pre_addr + 6'(i)), vecs[v].pre_v[16*i +: 16]);
            run_copy(vecs[v].src, vecs[v].dst, vecs[v].len, 0, -1,
                     (vecs[v].exp_done + 4 > 140) ? 140 : vecs[v].exp_done + 4,
                     dcyc, loads, bcyc, dcount);
            n_eff = (vecs[v].len > 7'd64) ? 64 : int'(vecs[v].len);
            ref_copy(vecs[v].src, vecs[v].dst, n_eff);
            chk($sformatf("v%0d_done_cycle", v), 64'(dcyc),   64'(vecs[v].exp_done));
            chk($sformatf("v%0d_done_count", v), 64'(dcount), 64'd1);
            chk($sformatf("v%0d_load_cycles", v), 64'(loads), 64'(vecs[v].exp_loads));
            chk($sformatf("v%0d_busy_cycles", v), 64'(bcyc),  64'(2 * vecs[v].exp_loads));
            cmp_image($sformatf("v%0d_mem_image", v));
            for (int i = 0; i < vecs[v].chk_n; i++)
                chk($sformatf("v%0d_word%0d", v, i), 64'(mem[6'(vecs[v].chk_addr + 6'(i))]),
                    64'(vecs[v].chk_v[16*i +: 16]));
        end

        // ---- start re-asserted through READ/WRITE/DONE of a len=5 copy ----
        fill_pattern();
        run_copy(6'd0, 6'd32, 7'd5, 2, 11, 20, dcyc, loads, bcyc, dcount);
        ref_copy(6'd0, 6'd32, 5);
        chk("ignore_start_done_count", 64'(dcount), 64'd1);
        chk("ignore_start_done_cycle", 64'(dcyc),   64'd11);
        chk("ignore_start_loads",      64'(loads),  64'd5);
        cmp_image("ignore_start_mem_image");

        // ---- reset during the 4th WRITE of a len=5 copy ----
        fill_pattern();
        @(negedge clk);
        src = 6'd0; dst = 6'd32; len = 7'd5; start = 1'b1;
        @(posedge clk);
        dcount = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) dcount++;
        end
        chk("abort_in_write", 64'({mem_load, busy, mem_address}), 64'({1'b1, 1'b1, 6'd35}));
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", 64'({busy, done, mem_load, mem_address, mem_in}), 64'd0);
        repeat (3) begin
            @(negedge clk);
            if (done) dcount++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("abort_no_done", 64'(dcount), 64'd0);
        chk("abort_words", {mem[32], mem[33], mem[34], mem[35]},
            {16'hC000, 16'hC001, 16'hC002, 16'hC023});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
